// File: rtl/run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// run_ctrl_pkg
// Shared definitions for the run controller:
//   - run_state_e : controller FSM encoding (IDLE, RUN, DRAIN, DONE)
//   - DEF_ADDR_W / DEF_DATA_W / DEF_CYC_W : default data-memory address width,
//     data-memory word width and cycle-counter width
// ---------------------------------------------------------------------------
package run_ctrl_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CYC_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } run_state_e;

endpackage : run_ctrl_pkg

// File: rtl/run_cycle_counter.sv
// ---------------------------------------------------------------------------
// run_cycle_counter
// Saturating up-counter with synchronous clear, count enable and a terminal
// compare output.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset, clears the count
//   clr_i    : synchronous clear (has priority over en_i)
//   en_i     : count enable; the count sticks at all-ones
//   count_o  : current count
//   term_o   : high while count_o equals TERM
// ---------------------------------------------------------------------------
module run_cycle_counter
    import run_ctrl_pkg::*;
#(
    parameter int               CYC_W = DEF_CYC_W,
    parameter logic [CYC_W-1:0] TERM  = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CYC_W-1:0] count_o,
    output logic             term_o
);

    logic [CYC_W-1:0] count_q;
    logic [CYC_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + CYC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == TERM);

endmodule : run_cycle_counter

// File: rtl/run_ctrl.sv
// ---------------------------------------------------------------------------
// run_ctrl
// Run controller and data-memory arbiter between the test host and the
// single-cycle core. The core is held in reset while the host owns memory
// (IDLE/DONE). On start the core is released and RUN cycles are counted
// until the core signals done or the cycle budget is exhausted; one DRAIN
// cycle follows, then memory ownership returns to the host (DONE).
//
// Ports:
//   clk, reset (async, active-low)
//   start                         run request, honoured in IDLE and DONE
//   host_req/host_we/host_addr/host_wdata -> host_gnt, host_rdata
//   core_we/core_addr/core_wdata/core_done -> core_rst, core_rdata
//   mem_we/mem_addr/mem_wdata  <- mem_rdata  (combinational-read memory)
//   busy (RUN|DRAIN), done (DONE), timeout (sticky), cycle_count
// ---------------------------------------------------------------------------
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          ADDR_W     = DEF_ADDR_W,
    parameter int          DATA_W     = DEF_DATA_W,
    parameter int          CYC_W      = DEF_CYC_W,
    parameter int unsigned MAX_CYCLES = 32'h0000_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              core_rst,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              core_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CYC_W-1:0]  cycle_count
);

    // The budget compare fires in the last allowed RUN cycle, i.e. while the
    // counter still shows MAX_CYCLES-1; the exit cycle itself is then counted.
    localparam logic [CYC_W-1:0] TERM_CNT = CYC_W'(MAX_CYCLES - 1);

    run_state_e state_q;
    run_state_e state_d;
    logic       timeout_q;
    logic       timeout_d;

    logic       start_acc;
    logic       run_exit;
    logic       cnt_term;
    logic       cnt_en;

    assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
    assign run_exit  = (state_q == RUN) && (core_done || cnt_term);
    assign cnt_en    = (state_q == RUN);

    run_cycle_counter #(
        .CYC_W (CYC_W),
        .TERM  (TERM_CNT)
    ) u_cycle_counter (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (start_acc),
        .en_i    (cnt_en),
        .count_o (cycle_count),
        .term_o  (cnt_term)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc) state_d = RUN;
            RUN:     if (run_exit)  state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (start_acc) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Timeout flag: cleared when a run is accepted, set only when the budget
    // ends the run; a core_done in the same cycle takes precedence.
    always_comb begin
        timeout_d = timeout_q;
        if (start_acc) begin
            timeout_d = 1'b0;
        end else if (run_exit && !core_done) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

    // Output logic: status flags and the memory ownership mux
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        core_rst  = 1'b1;
        host_gnt  = host_req;
        mem_we    = host_req & host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        case (state_q)
            RUN: begin
                busy      = 1'b1;
                core_rst  = 1'b0;
                host_gnt  = 1'b0;
                mem_we    = core_we;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
            end
            DRAIN: begin
                busy      = 1'b1;
                host_gnt  = 1'b0;
                mem_we    = 1'b0;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
            end
            DONE: begin
                done      = 1'b1;
            end
            default: ;
        endcase
        // While reset is held no one may write memory or be granted it,
        // even if the host keeps its request up.
        if (!reset) begin
            core_rst = 1'b1;
            host_gnt = 1'b0;
            mem_we   = 1'b0;
        end
    end

    // Read data is broadcast; each side qualifies it with its own grant.
    assign host_rdata = mem_rdata;
    assign core_rdata = mem_rdata;

endmodule : run_ctrl

// File: tb/tb_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_run_ctrl
// Three controller instances: u0 with the default cycle budget, u4 with
// MAX_CYCLES=4 and u1 with MAX_CYCLES=1. u0 is attached to a small memory
// model. Stimulus pushes expected host reads and expected run results into
// queues; a monitor on the falling edge pops them when the DUT grants a host
// read or raises done.
// ---------------------------------------------------------------------------
module tb_run_ctrl;

    typedef struct {
        int inst;
        int cnt;
        int to;
        int bz;
    } st_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } rd_t;

    logic        clk;
    logic        reset;
    logic        start0, start4, start1;
    logic        host_req, host_we;
    logic [7:0]  host_addr, host_wdata;
    logic        core_we, core_done;
    logic [7:0]  core_addr, core_wdata;

    logic [2:0]  gnt_v, core_rst_v, mem_we_v, busy_v, done_v, to_v;
    logic [7:0]  maddr_v [3];
    logic [7:0]  mwd_v   [3];
    logic [7:0]  hrd_v   [3];
    logic [7:0]  crd_v   [3];
    logic [15:0] cc_v    [3];
    logic [7:0]  mem_rdata0;

    logic [7:0]  mem [256];

    st_t exp_st[$];
    rd_t exp_rd[$];
    int  checks = 0;
    int  errors = 0;
    int  busy_cnt [3];
    logic [2:0] done_prev;

    run_ctrl u0 (
        .clk(clk), .reset(reset), .start(start0),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(gnt_v[0]), .host_rdata(hrd_v[0]),
        .core_rst(core_rst_v[0]), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(crd_v[0]), .core_done(core_done),
        .mem_we(mem_we_v[0]), .mem_addr(maddr_v[0]), .mem_wdata(mwd_v[0]),
        .mem_rdata(mem_rdata0), .busy(busy_v[0]), .done(done_v[0]),
        .timeout(to_v[0]), .cycle_count(cc_v[0])
    );

    run_ctrl #(.MAX_CYCLES(4)) u4 (
        .clk(clk), .reset(reset), .start(start4),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(gnt_v[1]), .host_rdata(hrd_v[1]),
        .core_rst(core_rst_v[1]), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(crd_v[1]), .core_done(core_done),
        .mem_we(mem_we_v[1]), .mem_addr(maddr_v[1]), .mem_wdata(mwd_v[1]),
        .mem_rdata(8'h00), .busy(busy_v[1]), .done(done_v[1]),
        .timeout(to_v[1]), .cycle_count(cc_v[1])
    );

    run_ctrl #(.MAX_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .start(start1),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(gnt_v[2]), .host_rdata(hrd_v[2]),
        .core_rst(core_rst_v[2]), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(crd_v[2]), .core_done(core_done),
        .mem_we(mem_we_v[2]), .mem_addr(maddr_v[2]), .mem_wdata(mwd_v[2]),
        .mem_rdata(8'h00), .busy(busy_v[2]), .done(done_v[2]),
        .timeout(to_v[2]), .cycle_count(cc_v[2])
    );

    // Data memory behind u0: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_we_v[0]) mem[maddr_v[0]] <= mwd_v[0];
    end
    assign mem_rdata0 = mem[maddr_v[0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        #1;
        chk("wr_gnt", gnt_v[0], 1);
        chk("wr_mem_we", mem_we_v[0], 1);
        chk("wr_core_rst", core_rst_v[0], 1);
        @(posedge clk);
        #1;
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a, input logic [7:0] d);
        exp_rd.push_back('{a, d});
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        @(posedge clk);
        #1;
        host_req = 1'b0;
    endtask

    // Monitor: host reads on u0, and run completions on every instance.
    initial begin
        rd_t r;
        st_t s;
        done_prev = '0;
        for (int i = 0; i < 3; i++) busy_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (gnt_v[0] && !host_we) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    r = exp_rd.pop_front();
                    chk("rd_addr", maddr_v[0], r.addr);
                    chk("host_rdata", hrd_v[0], r.data);
                    chk("core_rdata", crd_v[0], r.data);
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (!reset) begin
                    busy_cnt[i] = 0;
                end else begin
                    if (busy_v[i]) busy_cnt[i]++;
                    if (done_v[i] && !done_prev[i]) begin
                        if (exp_st.size() == 0) begin
                            chk("done_unexpected", i, 99);
                        end else begin
                            s = exp_st.pop_front();
                            chk("run_inst", i, s.inst);
                            chk("run_cycle_count", cc_v[i], s.cnt);
                            chk("run_timeout", to_v[i], s.to);
                            chk("run_busy_cycles", busy_cnt[i], s.bz);
                        end
                        busy_cnt[i] = 0;
                    end
                end
                done_prev[i] = done_v[i];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start0 = 1'b0; start4 = 1'b0; start1 = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h00; host_wdata = 8'h00;
        core_we = 1'b0; core_done = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
        repeat (2) tick();

        // Reset state, with a host request held up
        chk("rst_core_rst", core_rst_v[0], 1);
        chk("rst_busy", busy_v[0], 0);
        chk("rst_done", done_v[0], 0);
        chk("rst_gnt", gnt_v[0], 0);
        chk("rst_mem_we", mem_we_v[0], 0);
        chk("rst_cycle_count", cc_v[0], 0);
        chk("rst_timeout", to_v[0], 0);
        host_req = 1'b0; host_we = 1'b0;
        reset = 1'b1;
        tick();

        // Preload and readback in IDLE
        host_write(8'h10, 8'hA5);
        host_read(8'h10, 8'hA5);

        // Normal run: start together with a host write, core_done on cycle 5
        exp_st.push_back('{0, 5, 0, 6});
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h77;
        start0 = 1'b1;
        #1;
        chk("idle_start_gnt", gnt_v[0], 1);
        chk("idle_start_mem_we", mem_we_v[0], 1);
        tick();
        host_req = 1'b0; host_we = 1'b0; start0 = 1'b0;
        chk("run_core_rst", core_rst_v[0], 0);
        chk("run_busy", busy_v[0], 1);
        chk("run_cc_start", cc_v[0], 0);
        tick();
        // RUN cycle 2: host tries to write while the core stores
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'hFF;
        core_we = 1'b1; core_addr = 8'h20; core_wdata = 8'h3C;
        #1;
        chk("iso_gnt", gnt_v[0], 0);
        chk("iso_mem_we", mem_we_v[0], 1);
        chk("iso_mem_addr", maddr_v[0], 8'h20);
        chk("iso_mem_wdata", mwd_v[0], 8'h3C);
        tick();
        host_req = 1'b0; host_we = 1'b0; core_we = 1'b0;
        // RUN cycle 3: start must be ignored
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("ign_core_rst", core_rst_v[0], 0);
        tick();
        // RUN cycle 5
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        // DRAIN
        core_we = 1'b1; host_req = 1'b1; host_we = 1'b1;
        #1;
        chk("drain_mem_we", mem_we_v[0], 0);
        chk("drain_gnt", gnt_v[0], 0);
        chk("drain_core_rst", core_rst_v[0], 1);
        chk("drain_busy", busy_v[0], 1);
        tick();
        core_we = 1'b0; host_req = 1'b0; host_we = 1'b0;
        chk("done_flag", done_v[0], 1);
        chk("done_busy", busy_v[0], 0);
        host_read(8'h10, 8'hA5);
        host_read(8'h20, 8'h3C);
        host_read(8'h30, 8'h77);
        chk("cc_hold", cc_v[0], 5);

        // Restart from DONE, core_done on cycle 3
        exp_st.push_back('{0, 3, 0, 4});
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("restart_cc", cc_v[0], 0);
        chk("restart_core_rst", core_rst_v[0], 0);
        repeat (2) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        repeat (2) tick();

        // Budget of 4, no core_done
        exp_st.push_back('{1, 4, 1, 5});
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (6) tick();
        chk("to4_timeout", to_v[1], 1);
        chk("to4_done", done_v[1], 1);

        // Budget of 4, core_done in cycle 4 wins; restart clears timeout
        exp_st.push_back('{1, 4, 0, 5});
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("to4_restart_clr", to_v[1], 0);
        chk("to4_restart_cc", cc_v[1], 0);
        repeat (3) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        repeat (2) tick();
        chk("to4_tie_timeout", to_v[1], 0);

        // Budget of 1: single RUN cycle
        exp_st.push_back('{2, 1, 1, 2});
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("to1_core_rst", core_rst_v[2], 0);
        tick();
        chk("to1_drain_core_rst", core_rst_v[2], 1);
        tick();
        exp_st.push_back('{2, 1, 0, 2});
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        chk("to1_tie_timeout", to_v[2], 0);

        // Asynchronous reset in the middle of a run
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        core_we = 1'b1; core_addr = 8'h40; core_wdata = 8'h11;
        #1;
        chk("ar_pre_mem_we", mem_we_v[0], 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_core_rst", core_rst_v[0], 1);
        chk("ar_mem_we", mem_we_v[0], 0);
        chk("ar_busy", busy_v[0], 0);
        chk("ar_cc", cc_v[0], 0);
        tick();
        core_we = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("post_ar_cc", cc_v[0], 0);
        chk("post_ar_busy", busy_v[0], 0);
        chk("post_ar_done", done_v[0], 0);
        chk("post_ar_core_rst", core_rst_v[0], 1);

        repeat (2) tick();
        chk("pending_runs", exp_st.size(), 0);
        chk("pending_reads", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_run_ctrl

// File: doc/run_ctrl.md
# run_ctrl

Run controller and data-memory arbiter between the test host and the single-cycle core. Holds the core in reset while the host preloads data memory, releases it on `start`, and counts cycles until the core raises its done flag or a timeout expires. It then returns memory ownership to the host for result readback. It sits in `top_level` between the host/bench port, the core's data-memory port and the data memory.

## Interface
- `ADDR_W`, 8: data-memory address width
- `DATA_W`, 8: data-memory word width
- `CYC_W`, 16: cycle-counter width
- `MAX_CYCLES`, 16'hFFFF: RUN-cycle budget before timeout; must be ≥1
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  run request; honoured in IDLE and DONE only
- `host_req`  in  1  host memory access request
- `host_we`  in  1  host write enable, qualified by `host_req`
- `host_addr`  in  ADDR_W  host address
- `host_wdata`  in  DATA_W  host write data
- `host_gnt`  out  1  host owns memory this cycle
- `host_rdata`  out  DATA_W  read data, valid when `host_gnt`
- `core_rst`  out  1  active-high reset to core
- `core_we`  in  1  core store enable
- `core_addr`  in  ADDR_W  core address
- `core_wdata`  in  DATA_W  core store data
- `core_rdata`  out  DATA_W  core load data
- `core_done`  in  1  core halt flag
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory combinational read data
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  high in DONE
- `timeout`  out  1  sticky; last run ended by budget
- `cycle_count`  out  CYC_W  RUN cycles of current/last run

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `start`. Clear `cycle_count` and `timeout`.
- RUN → DRAIN on `core_done`, or when `cycle_count == MAX_CYCLES-1` (sets `timeout`). Simultaneous: `core_done` wins and `timeout` stays 0.
- DRAIN → DONE unconditionally after one cycle.
- DONE → RUN on `start`. Clear counter and flag. DONE otherwise holds.
- `start` in RUN or DRAIN is ignored.
- Ownership in IDLE and DONE: `host_gnt = host_req`. Memory address and data come from the host. `mem_we = host_req & host_we`.
- Ownership in RUN: memory signals come from the core, and `mem_we = core_we`. `host_gnt = 0` regardless of `host_req`.
- DRAIN: `mem_we = 0`, `host_gnt = 0`, address held from core.
- `host_rdata` and `core_rdata` both equal `mem_rdata`, with no qualification.
- `core_rst = 1` in every state except RUN.
- `cycle_count` increments once per RUN cycle, including the exit cycle. It saturates at all-ones and holds after exit.

## Timing
- Reset values:
  - FSM in IDLE, `cycle_count` 0.
  - `timeout`, `done`, `busy`, `host_gnt`, `mem_we` all 0.
  - `core_rst` 1, asserted combinationally from the reset state.
- Start latency: `start` sampled at edge N; RUN from N+1, `core_rst` low in cycle N+1.
- IDLE with `start` and `host_req` in the same cycle: the host access completes that cycle, then RUN.
- `core_done` sampled at edge M in RUN: DRAIN in cycle M+1, DONE in M+2. `cycle_count` equals the number of RUN cycles.
- Timeout with `MAX_CYCLES = 1`: RUN lasts exactly one cycle.
- `reset` asserted mid-run: immediate return to IDLE, `core_rst` high, `mem_we` 0 asynchronously.
- Host grant is combinational; there is no wait state.

## Structure
- `run_ctrl_pkg`: `run_state_e` enum (IDLE=0, RUN=1, DRAIN=2, DONE=3), plus shared `ADDR_W`/`DATA_W` defaults.
- One sub-module, `run_cycle_counter`: saturating CYC_W counter with clear, enable and terminal-compare output.
- The ownership mux stays in `run_ctrl`.

## Test plan
- **Preload:** in IDLE, host writes 8'hA5 to addr 8'h10, then reads it back → `host_gnt` = 1, `host_rdata` = 8'hA5, `core_rst` = 1 throughout.
- **Normal run:** `start`, core asserts `core_done` on its 5th RUN cycle → DONE two cycles later, `cycle_count` = 5, `timeout` = 0, `busy` high for exactly 6 cycles.
- **Isolation:** in RUN, host issues a write of 8'hFF to 8'h10 while the core writes 8'h3C to 8'h20 → `host_gnt` = 0 and memory receives only the core write. Host readback in DONE returns 8'hA5 at 8'h10 and 8'h3C at 8'h20.
- **Timeout:** `MAX_CYCLES` = 4, `core_done` never asserted → DONE with `timeout` = 1, `cycle_count` = 4. Repeat with `core_done` on cycle 4 → `timeout` = 0.
- **Restart and ignore:** `start` pulsed in RUN is ignored. `start` in DONE starts a new run with `cycle_count` cleared to 0 and `timeout` cleared to 0.
- **Async reset:** drop `reset` mid-RUN between clock edges → `core_rst` = 1 and `mem_we` = 0 before the next edge. After release, state is IDLE and `cycle_count` = 0.
